// File: rtl/ahb_slave_responder.sv
// AHB-Lite reference slave: word-addressed memory with wait states, ERROR responses and byte lanes.
// Define AHB_SLV_RAND_WAIT_EN to pick each beat's wait count from an LFSR.
module ahb_slave_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic [1:0]  hresp
);

  localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(MEM_DEPTH) * 33'd4;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [1:0]        trans_q;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic [3:0]        waitLoad;
  logic              accept;
  logic              addrOutOfRange;
  logic              misaligned;
  logic              beatBad;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  wordIdx;
  logic [3:0]        byteStrobe;
  logic              memWrEn;
  logic              unusedBits;
  logic [31:0]       mem [MEM_DEPTH];

  assign accept         = hsel & hready_in & htrans[1] & hready_out;
  assign addrOutOfRange = ({1'b0, haddr} < {1'b0, ADDR_BASE}) || ({1'b0, haddr} >= ADDR_LIMIT);
  assign misaligned     = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign beatBad        = addrOutOfRange || (hsize > 3'd2) || misaligned;

`ifdef AHB_SLV_RAND_WAIT_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11, stepped once per accepted beat.
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  randWait;

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign randWait = {1'b0, lfsr_q[3:0]} % 5'(WAIT_STATES + 1);
  assign waitLoad = randWait[3:0];
`else
  assign waitLoad = 4'(WAIT_STATES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE, DATA and ERR2 all drive hready_out high, so each can take a pipelined accept.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE, DATA, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          if (beatBad) begin
            state_d = ERR1;
          end else if (waitLoad != 4'd0) begin
            state_d   = WAIT;
            waitCnt_d = waitLoad;
          end else begin
            state_d = DATA;
          end
        end
      end
      WAIT: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q <= 4'd1) begin
          state_d = DATA;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    hrdata     = '0;
    case (state_q)
      WAIT: hready_out = 1'b0;
      DATA: begin
        if (!write_q) begin
          hrdata = mem[wordIdx];
        end
      end
      ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
      end
      ERR2:    hresp = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      trans_q   <= '0;
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        size_q  <= hsize;
        trans_q <= htrans;
      end
    end
  end

  assign offset  = addr_q - ADDR_BASE;
  assign wordIdx = offset[IDX_W+1:2];
  assign memWrEn = (state_q == DATA) && write_q;

  // Little-endian lane selection from the captured size and low address bits.
  always_comb begin
    byteStrobe = 4'b0000;
    case (size_q)
      3'd0:    byteStrobe = 4'b0001 << addr_q[1:0];
      3'd1:    byteStrobe = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    byteStrobe = 4'b1111;
      default: byteStrobe = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (memWrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (byteStrobe[i]) begin
          mem[wordIdx][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign unusedBits = ^{hburst, trans_q, offset};

endmodule

// File: doc/ahb_slave_responder.md
Name: ahb_slave_responder

Overview:
- AHB-Lite slave responder backed by an internal word-addressed memory.
- Sits on the same AHB interface our bridge testbench drives. Acts as the far end of that interface: accepts address/control from the master, inserts wait states, and returns hrdata/hready_out/hresp.
- Used as a reference slave for bring-up and for cross-checking bridge AHB-side timing, error response and byte-lane handling.

Parameters:
- ADDR_BASE, 32'h0000_0000, base address of the decoded region.
- MEM_DEPTH, 256, number of 32-bit words. Region size is MEM_DEPTH*4 bytes.
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15).

Ports:
- clk, input, 1, system clock. All logic is on posedge.
- reset, input, 1, asynchronous active-high reset.
- hsel, input, 1, slave select.
- haddr, input, 32, transfer address.
- hwrite, input, 1, 1 = write, 0 = read.
- hsize, input, 3, transfer size: 0 byte, 1 halfword, 2 word.
- hburst, input, 3, burst type. Ignored functionally; address is taken per beat.
- htrans, input, 2, 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwdata, input, 32, write data (data phase).
- hready_in, input, 1, bus-level ready; qualifies the address phase.
- hrdata, output, 32, read data.
- hready_out, output, 1, slave ready.
- hresp, output, 2, 00 OKAY, 01 ERROR.

Behaviour:
- Reset (asynchronous, any state): hready_out=1, hresp=00, hrdata=0, FSM=IDLE, captured address/control cleared. Memory contents are not cleared. Reset asserted mid-transfer aborts it with no memory update.
- Address phase accepted when hsel & hready_in & htrans[1] at posedge. haddr, hwrite, hsize and htrans are registered.
- IDLE, BUSY or unselected beats get a zero-wait OKAY response and do not touch memory.
- Error check at accept time. ERROR is raised if any of the following holds:
  - haddr < ADDR_BASE, or haddr >= ADDR_BASE + MEM_DEPTH*4.
  - hsize > 2.
  - Misalignment: halfword with haddr[0]=1, or word with haddr[1:0] != 0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> WAIT on accepted OK beat when WAIT_STATES>0. IDLE -> DATA when WAIT_STATES=0. IDLE -> ERR1 on accepted bad beat.
  - WAIT: hready_out=0, hresp=00. A down-counter is loaded with WAIT_STATES at accept; leave WAIT to DATA when the count reaches 1.
  - DATA: hready_out=1, hresp=00. Read: hrdata is driven with the word at (addr-ADDR_BASE)>>2, all 32 bits. Write: at the posedge ending DATA, hwdata is written using byte strobes. Strobes: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word -> all four. Little-endian. A new address phase may be accepted in the same cycle (pipelined). If one is, the next state follows the IDLE rules; otherwise go to IDLE.
  - ERR1: hready_out=0, hresp=01. Always -> ERR2.
  - ERR2: hready_out=1, hresp=01. No memory write. A pipelined accept here follows the IDLE rules.
- Latency: read data appears WAIT_STATES+1 cycles after the address-phase posedge.
- Address-phase signals are ignored while hready_in=0 or hready_out=0.
- hrdata = 0 in every cycle other than read DATA.
- A read immediately following a write to the same word returns the new data.

Optional Feature:
- Macro: AHB_SLV_RAND_WAIT_EN.
- Defined: the wait count per beat is lfsr[3:0] % (WAIT_STATES+1). The LFSR is a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, and advances once per accepted beat.
- Undefined: the wait count is fixed at WAIT_STATES and no LFSR logic is present.

Test Plan:
- WAIT_STATES=0: word write 32'hDEADBEEF to 0x10, then read 0x10 -> hready_out never low, hresp=00, hrdata=32'hDEADBEEF one cycle after the read address phase.
- WAIT_STATES=3: single read of 0x04 -> hready_out low for exactly 3 cycles, then high with data, hresp=00.
- Byte write 8'hA5 to 0x21, then word read 0x20 -> hrdata=32'h0000A500 (location pre-zeroed); other lanes unchanged.
- Read 0x400 with MEM_DEPTH=256 -> ERR1 cycle (hready_out=0, hresp=01), then ERR2 (hready_out=1, hresp=01). Halfword at 0x03 -> same two-cycle ERROR, memory untouched.
- 4-beat INCR write burst 0x40..0x4C, WAIT_STATES=1, then readback -> each beat has one wait cycle, pipelined accept in DATA, all four words correct.
- Assert reset during WAIT of a write -> outputs go to reset values immediately; a later read of the target returns the old value.
